// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and receiver FSM encodings.
// The uart_core transmitter is expected to adopt this package as well.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input, with a selectable
// reset level so idle-high lines come out of reset without a false edge.
module uart_sync #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {N{RESET_VAL}};
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, mid-bit data sampling and
// a valid/ready output holding register with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_sample;
    logic                 deliver;

    uart_sync #(
        .N         (SYNC_STAGES),
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    assign stop_sample = (state == ST_STOP) && (cnt == FULL_M1);
    assign deliver     = stop_sample && (rx_s == LINE_IDLE);
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;

    // Start is confirmed half a bit in; from then on every sample is one full
    // bit period later, so data and stop bits are all taken at mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_s == START_LVL) begin
                        state <= ST_START;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= (rx_s == START_LVL) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving mid-stop-bit lets a zero-gap next start be caught.
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= (rx_s == LINE_IDLE) ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (rx_s == LINE_IDLE) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Handshake: rdata is transferred on any cycle with rx_valid && rx_ready;
    // rx_valid then drops unless a new byte is delivered in that same cycle.
    // A delivery while rx_valid is held without rx_ready replaces the byte
    // and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_sample && (rx_s == START_LVL);
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver) begin
                rdata    <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level 8N1 driver, rising-edge byte
// scoreboard and pulse counters sampled on the falling clock edge.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int SS = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       RX       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int rise_cnt, fe_cnt, ov_cnt, busy_cnt, valid_cnt, rise_cyc, clash;
    int t0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rdata     (rdata),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        rise_cnt  = 0;
        fe_cnt    = 0;
        ov_cnt    = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
    endtask

    // Caller must be aligned to posedge+1; returns aligned so frames can abut.
    task automatic send_byte(input logic [7:0] d, input logic stop, output int start_cyc);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            cycles(OS);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("rx_byte", 32'(rdata), 32'(exp_b));
            end else begin
                check("rx_unexpected", 32'(rx_valid), 0);
            end
        end
        prev_valid = rx_valid;
        if (rx_valid)             valid_cnt++;
        if (frame_err)            fe_cnt++;
        if (overrun)              ov_cnt++;
        if (busy)                 busy_cnt++;
        if (frame_err && overrun) clash++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tmp;
        clash = 0;
        clear_counters();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata",     32'(rdata),     0);
        check("rst_rx_valid",  32'(rx_valid),  0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun",   32'(overrun),   0);
        check("rst_busy",      32'(busy),      0);
        rst_n = 1'b1;
        cycles(5);

        // 1: single byte, consumer always ready, latency from the pin
        rx_ready = 1'b1;
        clear_counters();
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, t0);
        cycles(10);
        check("t1_latency",  32'(rise_cyc - t0), 155);
        check("t1_valid_w",  32'(valid_cnt), 1);
        check("t1_fe",       32'(fe_cnt), 0);
        check("t1_ov",       32'(ov_cnt), 0);
        check("t1_q_empty",  32'(exp_q.size()), 0);

        // 2: 4-cycle glitch rejected at the half-bit sample
        clear_counters();
        RX = 1'b0;
        cycles(4);
        RX = 1'b1;
        cycles(40);
        check("t2_busy_cycles", 32'(busy_cnt), 8);
        check("t2_no_valid",    32'(valid_cnt), 0);
        check("t2_no_fe",       32'(fe_cnt), 0);

        // 3: bad stop bit followed by a long break, then a good byte
        clear_counters();
        send_byte(8'h3C, 1'b0, tmp);
        cycles(40 * OS);
        check("t3_fe_after_break", 32'(fe_cnt), 1);
        check("t3_busy_in_break",  32'(busy), 1);
        RX = 1'b1;
        cycles(32);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, tmp);
        cycles(10);
        check("t3_fe_total",  32'(fe_cnt), 1);
        check("t3_valid_w",   32'(valid_cnt), 1);
        check("t3_q_empty",   32'(exp_q.size()), 0);

        // 4: zero-gap frames with no consumer -> overrun
        rx_ready = 1'b0;
        clear_counters();
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1, tmp);
        check("t4_valid_1", 32'(rx_valid), 1);
        check("t4_rdata_1", 32'(rdata), 32'h01);
        check("t4_no_ov_1", 32'(ov_cnt), 0);
        send_byte(8'h80, 1'b1, tmp);
        check("t4_ov",      32'(ov_cnt), 1);
        check("t4_rdata_2", 32'(rdata), 32'h80);
        check("t4_valid_2", 32'(rx_valid), 1);
        check("t4_fe",      32'(fe_cnt), 0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        check("t4_valid_clr", 32'(rx_valid), 0);
        check("t4_rdata_kept", 32'(rdata), 32'h80);

        // 5: consumer accepts exactly on the delivery cycle of the next byte
        clear_counters();
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, tmp);
        check("t5_rdata_1", 32'(rdata), 32'h12);
        fork
            send_byte(8'h34, 1'b1, tmp);
            begin
                cycles(154);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        check("t5_valid_kept", 32'(rx_valid), 1);
        check("t5_rdata_2",    32'(rdata), 32'h34);
        check("t5_no_ov",      32'(ov_cnt), 0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        check("t5_valid_clr", 32'(rx_valid), 0);

        // 6: asynchronous reset during data bit 4, then a clean frame
        rx_ready = 1'b1;
        clear_counters();
        fork
            send_byte(8'hF0, 1'b1, tmp);
            begin
                cycles(88);
                check("t6_busy_pre", 32'(busy), 1);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("t6_rst_busy",  32'(busy), 0);
                check("t6_rst_rdata", 32'(rdata), 0);
                check("t6_rst_valid", 32'(rx_valid), 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        cycles(10);
        check("t6_no_partial", 32'(valid_cnt), 0);
        check("t6_no_fe",      32'(fe_cnt), 0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, tmp);
        cycles(10);
        check("t6_valid_w",   32'(valid_cnt), 1);
        check("t6_q_empty",   32'(exp_q.size()), 0);

        check("fe_ov_exclusive", 32'(clash), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
